// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// sequencer. The master side is the sequencer, the slave side is the datapath.
interface pipe_hazard_ctrl_if;
   logic [4:0] id_rs_i;
   logic [4:0] id_rt_i;
   logic       idex_memread_i;
   logic [4:0] idex_rt_i;
   logic       branch_taken_i;
   logic       exmem_memread_i;
   logic       exmem_memwrite_i;
   logic       dmem_ack_i;
   logic       dmem_req_o;
   logic       pc_write_o;
   logic       ifid_write_o;
   logic       ifid_flush_o;
   logic       idex_bubble_o;
   logic       exmem_hold_o;
   logic       memwb_bubble_o;

   modport master (
      input  id_rs_i, id_rt_i, idex_memread_i, idex_rt_i, branch_taken_i,
             exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
      output dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o,
             idex_bubble_o, exmem_hold_o, memwb_bubble_o
   );

   modport slave (
      output id_rs_i, id_rt_i, idex_memread_i, idex_rt_i, branch_taken_i,
             exmem_memread_i, exmem_memwrite_i, dmem_ack_i,
      input  dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o,
             idex_bubble_o, exmem_hold_o, memwb_bubble_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// taken-branch squash, data-memory wait with timeout, stall statistics.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   pipe_hazard_ctrl_if.master  hz,
   output logic                err_o,
   output logic [CNT_W-1:0]    stall_cnt_o
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

   state_t             state_q, state_d;
   logic [7:0]         wait_q, wait_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic memop, lu, memstall, timeout;
   logic pc_write;

   // Hazard decode; a timeout cycle releases the pipe exactly like an ack.
   always_comb begin
      memop    = hz.exmem_memread_i | hz.exmem_memwrite_i;
      lu       = hz.idex_memread_i && (hz.idex_rt_i != 5'd0) &&
                 ((hz.idex_rt_i == hz.id_rs_i) || (hz.idex_rt_i == hz.id_rt_i));
      timeout  = (state_q == MEM_WAIT) && memop && !hz.dmem_ack_i &&
                 (wait_q >= TIMEOUT_LIM);
      memstall = memop && !hz.dmem_ack_i && !timeout;
   end

   // Pipeline controls; forced to run defaults while reset is asserted.
   always_comb begin
      hz.dmem_req_o     = 1'b0;
      pc_write          = 1'b1;
      hz.ifid_write_o   = 1'b1;
      hz.ifid_flush_o   = 1'b0;
      hz.idex_bubble_o  = 1'b0;
      hz.exmem_hold_o   = 1'b0;
      hz.memwb_bubble_o = 1'b0;
      if (rst_i) begin
         hz.dmem_req_o = memop;
         if (memstall) begin
            pc_write          = 1'b0;
            hz.ifid_write_o   = 1'b0;
            hz.exmem_hold_o   = 1'b1;
            hz.memwb_bubble_o = 1'b1;
         end else begin
            // abandoned access must not write back
            hz.memwb_bubble_o = timeout;
            if (lu) begin
               pc_write         = 1'b0;
               hz.ifid_write_o  = 1'b0;
               hz.idex_bubble_o = 1'b1;
            end else if (hz.branch_taken_i) begin
               hz.ifid_flush_o = 1'b1;
            end
         end
      end
      hz.pc_write_o = pc_write;
   end

   // Next-state: memory wait tracking, sticky error, saturating stall count.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      err_d       = err_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         RUN: begin
            if (memstall) begin
               state_d = MEM_WAIT;
               wait_d  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (!memop || hz.dmem_ack_i || timeout) begin
               state_d = RUN;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
      if (timeout) err_d = 1'b1;
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= RUN;
         wait_q      <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign err_o       = err_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
